// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller for the 5-stage RISC-V core.
//                Produces stall/flush controls for the IF/ID, ID/EX and
//                EX/MEM pipeline registers, EX-stage forwarding selects,
//                sequencing of multi-cycle mul/div operations held in EX,
//                instruction-memory wait-state handling, and stall/flush
//                event counters for performance debug.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MULDIV_LAT = 4,   // cycles a mul/div occupies EX, 2..15
  parameter int CNT_W      = 32   // performance counter width
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active-low

  // ID-stage sources
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,

  // EX-stage instruction
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             MulDivE,
  input  logic             PCSrcE,

  // MEM / WB writers
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,

  // Instruction memory handshake
  input  logic             IMemReady,

  // Pipeline controls
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,

  // Performance counters
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // The first stall cycle is spent in IDLE, so BUSY only has to cover
  // MULDIV_LAT-2 further cycles before DONE releases the instruction.
  localparam logic [3:0] C_BUSY_LOAD = 4'(MULDIV_LAT - 2);
  // With a two-cycle latency there is no BUSY phase at all.
  localparam bit         C_SKIP_BUSY = (MULDIV_LAT <= 2);

  localparam logic [1:0] C_FWD_RF  = 2'b00;
  localparam logic [1:0] C_FWD_WB  = 2'b01;
  localparam logic [1:0] C_FWD_MEM = 2'b10;

  // --------------------------------------------------------------------------
  // Mul/div sequencer state
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  md_state_t  md_state_q, md_state_d;
  logic [3:0] md_cnt_q,   md_cnt_d;
  logic       md_stall;

  // Counters
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Raw (pre-reset-gating) hazard terms
  logic       lw_stall;
  logic       im_wait;
  logic       stall_f_raw;
  logic       stall_d_raw;
  logic       flush_d_raw;
  logic       flush_e_raw;
  logic       branch_accept;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  // --------------------------------------------------------------------------
  // Forwarding select: the younger MEM result has priority over WB, and x0
  // is never forwarded since it always reads as zero.
  // --------------------------------------------------------------------------
  function automatic logic [1:0] fwd_select(input logic [4:0] rs,
                                            input logic       wr_m,
                                            input logic [4:0] rd_m,
                                            input logic       wr_w,
                                            input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = C_FWD_RF;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = C_FWD_MEM;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = C_FWD_WB;
    end
    return sel;
  endfunction

  // Operand forwarding selects for both EX sources
  always_comb begin
    fwd_a_raw = fwd_select(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    fwd_b_raw = fwd_select(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
  end

  // --------------------------------------------------------------------------
  // Mul/div sequencing: stall while the unit is working, release in DONE.
  // DONE always returns to IDLE so a back-to-back mul/div restarts cleanly.
  // --------------------------------------------------------------------------
  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    md_stall   = 1'b0;
    case (md_state_q)
      ST_IDLE: begin
        if (MulDivE) begin
          md_stall = 1'b1;
          if (C_SKIP_BUSY) begin
            md_state_d = ST_DONE;
          end else begin
            md_state_d = ST_BUSY;
            md_cnt_d   = C_BUSY_LOAD;
          end
        end
      end
      ST_BUSY: begin
        md_stall = 1'b1;
        md_cnt_d = md_cnt_q - 4'd1;
        if (md_cnt_q == 4'd1) begin
          md_state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        md_state_d = ST_IDLE;
      end
      default: begin
        md_state_d = ST_IDLE;
      end
    endcase
  end

  // Mul/div sequencer registers; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_state_q <= ST_IDLE;
      md_cnt_q   <= 4'd0;
    end else begin
      md_state_q <= md_state_d;
      md_cnt_q   <= md_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Hazard equations. A mul/div stall dominates everything: the whole front
  // end holds and a bubble goes into MEM. A taken branch beats an imem wait
  // so the redirect loads and the pending fetch is dropped. A load-use stall
  // holds ID instead of letting an imem bubble overwrite it.
  // --------------------------------------------------------------------------
  always_comb begin
    lw_stall      = ResultSrcE0 && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
    im_wait       = ~IMemReady;
    stall_d_raw   = md_stall | lw_stall;
    stall_f_raw   = md_stall | lw_stall | (im_wait & ~PCSrcE);
    flush_e_raw   = (lw_stall | PCSrcE) & ~md_stall;
    flush_d_raw   = (PCSrcE | (im_wait & ~stall_d_raw)) & ~md_stall;
    branch_accept = PCSrcE & ~md_stall;
  end

  // Drive outputs; everything is held at zero while reset is asserted
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    ForwardAE = C_FWD_RF;
    ForwardBE = C_FWD_RF;
    if (reset) begin
      StallF    = stall_f_raw;
      StallD    = stall_d_raw;
      StallE    = md_stall;
      FlushD    = flush_d_raw;
      FlushE    = flush_e_raw;
      FlushM    = md_stall;
      ForwardAE = fwd_a_raw;
      ForwardBE = fwd_b_raw;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters, free-running modulo 2^CNT_W
  // --------------------------------------------------------------------------
  // Next-count: stall cycles seen at the PC, and branches actually taken
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f_raw) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (branch_accept) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Two instances share the
//                stimulus: one with MULDIV_LAT=4, one with MULDIV_LAT=2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, MulDivE, PCSrcE, RegWriteM, RegWriteW, IMemReady;

  // MULDIV_LAT=4 instance
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCount, FlushCount;

  // MULDIV_LAT=2 instance
  logic        StallF2, StallD2, StallE2, FlushD2, FlushE2, FlushM2;
  logic [1:0]  ForwardAE2, ForwardBE2;
  logic [31:0] StallCount2, FlushCount2;

  hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .MulDivE(MulDivE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .IMemReady(IMemReady),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  hazard_ctrl #(.MULDIV_LAT(2), .CNT_W(32)) dut2 (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .MulDivE(MulDivE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .IMemReady(IMemReady),
    .StallF(StallF2), .StallD(StallD2), .StallE(StallE2),
    .FlushD(FlushD2), .FlushE(FlushE2), .FlushM(FlushM2),
    .ForwardAE(ForwardAE2), .ForwardBE(ForwardBE2),
    .StallCount(StallCount2), .FlushCount(FlushCount2)
  );

  wire [5:0] ctl_a = {StallF, StallD, StallE, FlushD, FlushE, FlushM};
  wire [5:0] ctl_b = {StallF2, StallD2, StallE2, FlushD2, FlushE2, FlushM2};

  typedef struct packed {
    logic [5:0]  ctl;
    logic [5:0]  ctl2;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] sc;
    logic [31:0] fc;
    logic        sf;
    logic        br_acc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state: extra stall cycles still owed after the first,
  // and a flag for the release cycle.
  int          m_rem  = 0;
  bit          m_done = 1'b0;
  int          m2_rem  = 0;
  bit          m2_done = 1'b0;
  logic [31:0] m_sc = 32'd0;
  logic [31:0] m_fc = 32'd0;

  function automatic logic [1:0] fsel(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic md_of(input int rem, input bit done);
    if (done) return 1'b0;
    if (rem > 0) return 1'b1;
    return MulDivE;
  endfunction

  // Returns {StallF, StallD, StallE, FlushD, FlushE, FlushM}
  function automatic logic [5:0] ctl_of(input logic md);
    logic lw, imw, sf, sd, fd, fe;
    lw  = ResultSrcE0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    imw = !IMemReady;
    sd  = md | lw;
    sf  = md | lw | (imw & !PCSrcE);
    fe  = (lw | PCSrcE) & !md;
    fd  = (PCSrcE | (imw & !sd)) & !md;
    return {sf, sd, md, fd, fe, md};
  endfunction

  task automatic push_expect(input string tag, output exp_t e);
    logic md, md2;
    md  = md_of(m_rem, m_done);
    md2 = md_of(m2_rem, m2_done);
    e.ctl    = ctl_of(md);
    e.ctl2   = ctl_of(md2);
    e.fa     = fsel(Rs1E);
    e.fb     = fsel(Rs2E);
    e.sc     = m_sc;
    e.fc     = m_fc;
    e.sf     = e.ctl[5];
    e.br_acc = PCSrcE & !md;
    if (!reset) begin
      e.ctl  = 6'd0;
      e.ctl2 = 6'd0;
      e.fa   = 2'b00;
      e.fb   = 2'b00;
      e.sc   = 32'd0;
      e.fc   = 32'd0;
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic adv(inout int rem, inout bit done, input int lat);
    if (done) begin
      done = 1'b0;
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) done = 1'b1;
    end else if (MulDivE) begin
      rem = lat - 2;
      if (rem == 0) done = 1'b1;
    end
  endtask

  task automatic model_clock(input exp_t e);
    if (!reset) begin
      m_rem = 0; m_done = 1'b0; m2_rem = 0; m2_done = 1'b0;
      m_sc = 32'd0; m_fc = 32'd0;
    end else begin
      m_sc = m_sc + 32'(e.sf);
      m_fc = m_fc + 32'(e.br_acc);
      adv(m_rem, m_done, 4);
      adv(m2_rem, m2_done, 2);
    end
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (ctl_a === e.ctl) else begin
      errors++;
      $error("FAIL %s ctl{SF,SD,SE,FD,FE,FM} observed=%b expected=%b", t, ctl_a, e.ctl);
    end
    checks++;
    assert (ctl_b === e.ctl2) else begin
      errors++;
      $error("FAIL %s lat2_ctl observed=%b expected=%b", t, ctl_b, e.ctl2);
    end
    checks++;
    assert (ForwardAE === e.fa) else begin
      errors++;
      $error("FAIL %s ForwardAE observed=%b expected=%b", t, ForwardAE, e.fa);
    end
    checks++;
    assert (ForwardBE === e.fb) else begin
      errors++;
      $error("FAIL %s ForwardBE observed=%b expected=%b", t, ForwardBE, e.fb);
    end
    checks++;
    assert (StallCount === e.sc) else begin
      errors++;
      $error("FAIL %s StallCount observed=%0d expected=%0d", t, StallCount, e.sc);
    end
    checks++;
    assert (FlushCount === e.fc) else begin
      errors++;
      $error("FAIL %s FlushCount observed=%0d expected=%0d", t, FlushCount, e.fc);
    end
  endtask

  // One cycle: expectation pushed when inputs are applied, compared mid-cycle
  task automatic step(input string tag);
    exp_t e;
    push_expect(tag, e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    model_clock(e);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
    RdM = 5'd0; RdW = 5'd0;
    ResultSrcE0 = 1'b0; MulDivE = 1'b0; PCSrcE = 1'b0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; IMemReady = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    step("reset");
    reset = 1'b1;
    step("idle");

    // Forwarding priority
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
    Rs1E = 5'd5; Rs2E = 5'd5;
    step("fwd_mem");
    RegWriteM = 1'b0;
    step("fwd_wb");
    Rs1E = 5'd0;
    step("fwd_none");
    RdW = 5'd0; Rs2E = 5'd0;
    step("fwd_x0");
    clear_inputs();

    // Load-use
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    step("lw_use");
    clear_inputs();
    step("lw_after");

    // Mul/div, held high: covers the first sequence and a back-to-back one
    MulDivE = 1'b1;
    for (int i = 0; i < 8; i++) step($sformatf("md_%0d", i));
    MulDivE = 1'b0;
    step("md_end");

    // Branch taken
    PCSrcE = 1'b1;
    step("branch");
    PCSrcE = 1'b0;
    step("branch_after");

    // Branch during a mul/div stall is masked
    MulDivE = 1'b1;
    step("md_br_start");
    PCSrcE = 1'b1;
    step("md_br_busy0");
    step("md_br_busy1");
    step("md_br_done");
    clear_inputs();
    step("md_br_after");

    // Imem wait, then wait coinciding with a taken branch
    IMemReady = 1'b0;
    step("imwait0");
    step("imwait1");
    PCSrcE = 1'b1;
    step("imwait_branch");
    clear_inputs();
    step("imwait_after");

    // Reset asserted during the second mul/div stall cycle
    MulDivE = 1'b1;
    step("rst_md0");
    reset = 1'b0;
    step("rst_mid");
    reset = 1'b1;
    MulDivE = 1'b0;
    step("post_rst0");
    step("post_rst1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
